// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conv_pkg
// Brief   : Shared widths, buffer limits and controller states for the conv block
// Revision: 1.0
// ============================================================================
package conv_pkg;

  localparam int C_PIXEL_WIDTH  = 16;
  localparam int C_KERNEL_WIDTH = 16;
  localparam int C_RESULT_WIDTH = 48;
  localparam int C_MAX_IMG      = 64;
  localparam int C_MAX_CH       = 256;
  localparam int C_IDX_W        = 6;
  localparam int C_TAPS         = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    RECV,
    COMP,
    OUT
  } state_t;

  // Row-major 3x3 tap number from the kernel row/column
  function automatic logic [3:0] tap_index(input logic [1:0] kr, input logic [1:0] kc);
    return 4'(kr) * 4'd3 + 4'(kc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_unit.sv
`default_nettype none
// ============================================================================
// Module  : conv_mac_unit
// Brief   : Signed tap multiply, sign-extension and 48-bit wrap-around accumulate
// Revision: 1.0
// ============================================================================
module conv_mac_unit
  import conv_pkg::*;
(
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      en,
  input  logic                      clear,
  input  logic [C_PIXEL_WIDTH-1:0]  pixel,
  input  logic [C_KERNEL_WIDTH-1:0] weight,
  output logic [C_RESULT_WIDTH-1:0] sum
);

  localparam int C_PROD_W = C_PIXEL_WIDTH + C_KERNEL_WIDTH;

  logic signed [C_PROD_W-1:0] w_product;
  logic [C_RESULT_WIDTH-1:0]  r_acc;

  assign w_product = $signed(pixel) * $signed(weight);

  // sum is the running total including this cycle's tap, so the caller can use it on the last tap
  assign sum = (clear ? '0 : r_acc)
             + {{(C_RESULT_WIDTH-C_PROD_W){w_product[C_PROD_W-1]}}, w_product};

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/convolution_top_alt.sv
`default_nettype none
// ============================================================================
// Module  : convolution_top_alt
// Brief   : Multi-channel 3x3 zero-padded convolution over AXI-Stream, one tap per cycle
// Revision: 1.0
// ============================================================================
module convolution_top_alt
  import conv_pkg::*;
#(
  parameter int PIXEL_WIDTH  = C_PIXEL_WIDTH,
  parameter int KERNEL_WIDTH = C_KERNEL_WIDTH,
  parameter int RESULT_WIDTH = C_RESULT_WIDTH,
  parameter int MAX_IMG      = C_MAX_IMG,
  parameter int MAX_CH       = C_MAX_CH
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    Load_kernel_BRAM,
  input  logic [7:0]              Image_size,
  input  logic [8:0]              Channel_size,
  input  logic [255:0]            kernel_BRAM_doutb,
  output logic                    enb_kernel_BRAM,
  output logic [7:0]              kernel_BRAM_counter_out,
  input  logic [RESULT_WIDTH-1:0] bias_BRAM_douta,
  input  logic [PIXEL_WIDTH-1:0]  s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [63:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int C_KWORD_W = C_TAPS * KERNEL_WIDTH;

  state_t               r_state;
  logic [7:0]           r_kcnt;
  logic [7:0]           r_ch;
  logic [C_IDX_W-1:0]   r_row;
  logic [C_IDX_W-1:0]   r_col;
  logic [1:0]           r_kr;
  logic [1:0]           r_kc;

  logic [C_KWORD_W-1:0]    r_kernel [MAX_CH];
  logic [PIXEL_WIDTH-1:0]  r_frame  [MAX_IMG*MAX_IMG];
  logic [RESULT_WIDTH-1:0] r_psum   [MAX_IMG*MAX_IMG];

  logic [2*C_IDX_W-1:0]    w_addr;
  logic [2*C_IDX_W-1:0]    w_tap_addr;
  logic [C_IDX_W-1:0]      w_tap_row;
  logic [C_IDX_W-1:0]      w_tap_col;
  logic [C_IDX_W-1:0]      w_next_row;
  logic [C_IDX_W-1:0]      w_next_col;
  logic [7:0]              w_row_p1;
  logic [7:0]              w_col_p1;
  logic                    w_tap_in;
  logic                    w_last_col;
  logic                    w_last_row;
  logic                    w_last_pix;
  logic                    w_last_tap;
  logic                    w_last_ch;
  logic                    w_beat;
  logic [C_KWORD_W-1:0]    w_kword;
  logic [KERNEL_WIDTH-1:0] w_weight;
  logic [PIXEL_WIDTH-1:0]  w_pixel;
  logic [RESULT_WIDTH-1:0] w_tap_sum;
  logic [RESULT_WIDTH-1:0] w_psum_total;
  logic [RESULT_WIDTH-1:0] w_out;
  logic                    w_unused;

  assign kernel_BRAM_counter_out = r_kcnt;
  assign w_unused = ^{kernel_BRAM_doutb[255:C_KWORD_W], s_axis_tlast};

  assign w_addr     = {r_row, r_col};
  assign w_last_col = (8'(r_col) == Image_size - 8'd1);
  assign w_last_row = (8'(r_row) == Image_size - 8'd1);
  assign w_last_pix = w_last_row && w_last_col;
  assign w_last_tap = (r_kr == 2'd2) && (r_kc == 2'd2);
  assign w_last_ch  = ({1'b0, r_ch} == Channel_size - 9'd1);
  assign w_beat     = s_axis_tvalid && s_axis_tready;
  assign w_next_col = w_last_col ? '0 : r_col + C_IDX_W'(1);
  assign w_next_row = w_last_col ? r_row + C_IDX_W'(1) : r_row;

  // Tap coordinates are kept with a +1 offset so the zero-pad border is a plain unsigned range test
  assign w_row_p1   = 8'(r_row) + 8'(r_kr);
  assign w_col_p1   = 8'(r_col) + 8'(r_kc);
  assign w_tap_in   = (w_row_p1 != 8'd0) && (w_row_p1 <= Image_size)
                   && (w_col_p1 != 8'd0) && (w_col_p1 <= Image_size);
  assign w_tap_row  = r_row + C_IDX_W'(r_kr) - C_IDX_W'(1);
  assign w_tap_col  = r_col + C_IDX_W'(r_kc) - C_IDX_W'(1);
  assign w_tap_addr = {w_tap_row, w_tap_col};

  assign w_kword  = r_kernel[r_ch];
  assign w_weight = w_kword[tap_index(r_kr, r_kc)*KERNEL_WIDTH +: KERNEL_WIDTH];
  assign w_pixel  = w_tap_in ? r_frame[w_tap_addr] : '0;

  conv_mac_unit u_mac (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (r_state == COMP),
    .clear   ((r_kr == 2'd0) && (r_kc == 2'd0)),
    .pixel   (w_pixel),
    .weight  (w_weight),
    .sum     (w_tap_sum)
  );

  // Channel 0 overwrites, which makes psum contents left over from an abandoned frame harmless
  assign w_psum_total = (r_ch == 8'd0) ? w_tap_sum : r_psum[w_addr] + w_tap_sum;
  assign w_out        = w_psum_total + bias_BRAM_douta;

  always_ff @(posedge clk) begin
    if (aresetn) begin
      if (r_state == LOAD_K)
        r_kernel[r_kcnt] <= kernel_BRAM_doutb[C_KWORD_W-1:0];
      if (r_state == RECV && w_beat)
        r_frame[w_addr] <= s_axis_tdata;
      if (r_state == COMP && w_last_tap)
        r_psum[w_addr] <= w_psum_total;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state         <= IDLE;
      r_kcnt          <= '0;
      r_ch            <= '0;
      r_row           <= '0;
      r_col           <= '0;
      r_kr            <= '0;
      r_kc            <= '0;
      enb_kernel_BRAM <= 1'b0;
      s_axis_tready   <= 1'b0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Load_kernel_BRAM) begin
            r_state         <= LOAD_K;
            enb_kernel_BRAM <= 1'b1;
            r_kcnt          <= '0;
          end else if (s_axis_tvalid) begin
            r_state       <= RECV;
            s_axis_tready <= 1'b1;
            r_ch          <= '0;
            r_row         <= '0;
            r_col         <= '0;
          end
        end
        LOAD_K: begin
          if (!Load_kernel_BRAM) begin
            r_state         <= IDLE;
            enb_kernel_BRAM <= 1'b0;
            r_kcnt          <= '0;
          end else if ({1'b0, r_kcnt} != Channel_size - 9'd1) begin
            r_kcnt <= r_kcnt + 8'd1;
          end
        end
        RECV: begin
          if (w_beat) begin
            if (w_last_pix) begin
              r_state       <= COMP;
              s_axis_tready <= 1'b0;
              r_row         <= '0;
              r_col         <= '0;
              r_kr          <= '0;
              r_kc          <= '0;
            end else begin
              r_row <= w_next_row;
              r_col <= w_next_col;
            end
          end
        end
        COMP: begin
          if (r_kc == 2'd2) begin
            r_kc <= '0;
            r_kr <= w_last_tap ? 2'd0 : r_kr + 2'd1;
          end else begin
            r_kc <= r_kc + 2'd1;
          end
          if (w_last_tap) begin
            if (w_last_ch) begin
              r_state       <= OUT;
              m_axis_tdata  <= {{(64-RESULT_WIDTH){w_out[RESULT_WIDTH-1]}}, w_out};
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= w_last_pix;
            end else if (w_last_pix) begin
              r_state       <= RECV;
              s_axis_tready <= 1'b1;
              r_ch          <= r_ch + 8'd1;
              r_row         <= '0;
              r_col         <= '0;
            end else begin
              r_row <= w_next_row;
              r_col <= w_next_col;
            end
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            if (w_last_pix) begin
              r_state <= IDLE;
              r_row   <= '0;
              r_col   <= '0;
            end else begin
              r_state <= COMP;
              r_row   <= w_next_row;
              r_col   <= w_next_col;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_convolution_top_alt.sv
`default_nettype none
// ============================================================================
// Module  : tb_convolution_top_alt
// Brief   : Randomized frames scored against a direct 3x3 zero-padded convolution model
// Revision: 1.0
// ============================================================================
module tb_convolution_top_alt;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         Load_kernel_BRAM;
  logic [7:0]   Image_size;
  logic [8:0]   Channel_size;
  logic [255:0] kernel_BRAM_doutb;
  logic         enb_kernel_BRAM;
  logic [7:0]   kernel_BRAM_counter_out;
  logic [47:0]  bias_BRAM_douta;
  logic [15:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  logic [255:0] kmem [256];
  logic [15:0]  kw   [256][9];
  logic [15:0]  img  [256][64];
  logic [64:0]  exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int rdy_mode    = 1;
  bit gaps        = 1'b0;

  always #5 clk = ~clk;

  assign kernel_BRAM_doutb = kmem[kernel_BRAM_counter_out];

  convolution_top_alt dut (
    .clk                     (clk),
    .aresetn                 (aresetn),
    .Load_kernel_BRAM        (Load_kernel_BRAM),
    .Image_size              (Image_size),
    .Channel_size            (Channel_size),
    .kernel_BRAM_doutb       (kernel_BRAM_doutb),
    .enb_kernel_BRAM         (enb_kernel_BRAM),
    .kernel_BRAM_counter_out (kernel_BRAM_counter_out),
    .bias_BRAM_douta         (bias_BRAM_douta),
    .s_axis_tdata            (s_axis_tdata),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tlast            (s_axis_tlast),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tlast            (m_axis_tlast)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output sink: 0 = never ready, 1 = always ready, 2 = random backpressure
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted output and checks stalled outputs stay put
  initial begin
    logic        stalled;
    logic [64:0] held;
    logic [64:0] got;
    logic [64:0] e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        got = {m_axis_tlast, m_axis_tdata};
        if (stalled) begin
          check("hold_valid", 65'(m_axis_tvalid), 65'd1);
          check("hold_data", got, held);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got %h, expected no output", got);
          end else begin
            e = exp_q.pop_front();
            check("pixel_out", got, e);
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held    = got;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1);
  end

  task automatic load_kernels(input int c);
    Channel_size = 9'(c);
    for (int ch = 0; ch < 256; ch++) begin
      for (int j = 0; j < 8; j++) kmem[ch][32*j +: 32] = $urandom;
      for (int k = 0; k < 9; k++) kmem[ch][16*k +: 16] = kw[ch][k];
    end
    @(posedge clk); #1;
    Load_kernel_BRAM = 1'b1;
    for (int i = 0; i < c + 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("load_enb", 65'(enb_kernel_BRAM), 65'd1);
      check("load_cnt", 65'(kernel_BRAM_counter_out), 65'((i < c) ? i : c - 1));
    end
    @(posedge clk); #1;
    Load_kernel_BRAM = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("load_drop_enb", 65'(enb_kernel_BRAM), 65'd0);
    check("load_drop_cnt", 65'(kernel_BRAM_counter_out), 65'd0);
  endtask

  task automatic send_beat(input logic [15:0] d);
    int   n;
    logic rdy;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 5000) begin
        vectors++;
        miscompares++;
        $display("FAIL beat_timeout: got no tready, expected tready within 5000 cycles");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference: every output is the plain 3x3 zero-padded sum over all channels, plus bias, mod 2^48
  task automatic run_frame(input int n, input int c, input logic [47:0] b);
    longint      acc;
    logic [47:0] t;
    int          rr;
    int          cc;
    Image_size      = 8'(n);
    bias_BRAM_douta = b;
    for (int r = 0; r < n; r++) begin
      for (int col = 0; col < n; col++) begin
        acc = 0;
        for (int ch = 0; ch < c; ch++)
          for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++) begin
              rr = r + kr - 1;
              cc = col + kc - 1;
              if (rr >= 0 && rr < n && cc >= 0 && cc < n)
                acc += longint'($signed(kw[ch][3*kr+kc])) * longint'($signed(img[ch][rr*n+cc]));
            end
        t = acc[47:0] + b;
        exp_q.push_back({(r == n-1 && col == n-1), {{16{t[47]}}, t}});
      end
    end
    for (int ch = 0; ch < c; ch++)
      for (int i = 0; i < n*n; i++) send_beat(img[ch][i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60000) begin
      @(posedge clk);
      n++;
    end
    check(name, 65'(exp_q.size()), 65'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_w4(input int c, input logic [15:0] v);
    for (int ch = 0; ch < c; ch++)
      for (int k = 0; k < 9; k++) kw[ch][k] = (k == 4) ? v : 16'd0;
  endtask

  task automatic fill_img(input int c, input int n, input logic [15:0] v, input bit rnd);
    for (int ch = 0; ch < c; ch++)
      for (int i = 0; i < n*n; i++) img[ch][i] = rnd ? 16'($urandom) : v;
  endtask

  initial begin
    int          lat;
    int          n;
    int          c;
    logic [47:0] b;

    aresetn          = 1'b0;
    Load_kernel_BRAM = 1'b0;
    Image_size       = 8'd4;
    Channel_size     = 9'd1;
    bias_BRAM_douta  = '0;
    s_axis_tdata     = '0;
    s_axis_tvalid    = 1'b1;
    s_axis_tlast     = 1'b0;
    for (int ch = 0; ch < 256; ch++) kmem[ch] = '0;

    // Reset held 10 cycles with a pending stream beat that must not be accepted
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_enb", 65'(enb_kernel_BRAM), 65'd0);
    check("rst_cnt", 65'(kernel_BRAM_counter_out), 65'd0);
    check("rst_tready", 65'(s_axis_tready), 65'd0);
    check("rst_tvalid", 65'(m_axis_tvalid), 65'd0);
    check("rst_tlast", 65'(m_axis_tlast), 65'd0);
    check("rst_tdata", {1'b0, m_axis_tdata}, 65'd0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    aresetn       = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 256-channel kernel load, centre weight 1 on every channel
    set_w4(256, 16'd1);
    load_kernels(256);

    // Single channel reusing the stored channel-0 kernel: identity
    Channel_size = 9'd1;
    fill_img(1, 4, 16'd1, 1'b0);
    run_frame(4, 1, 48'd0);
    drain("drain_identity");

    // All-ones kernel: corner/edge/interior neighbourhood counts
    for (int k = 0; k < 9; k++) kw[0][k] = 16'd1;
    load_kernels(1);
    run_frame(4, 1, 48'd0);
    drain("drain_ones");

    // 256 channels accumulated plus bias
    set_w4(256, 16'd1);
    load_kernels(256);
    fill_img(256, 4, 16'd1, 1'b0);
    run_frame(4, 256, 48'd5);
    drain("drain_256ch");

    // Negative result, first-output latency and output held under backpressure
    set_w4(1, 16'd3);
    load_kernels(1);
    fill_img(1, 4, 16'hFFFE, 1'b0);
    rdy_mode = 0;
    run_frame(4, 1, 48'd0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!m_axis_tvalid && lat < 50);
    check("first_out_latency", 65'(lat), 65'd9);
    repeat (5) @(posedge clk);
    #1;
    rdy_mode = 1;
    drain("drain_negative");

    // Reset mid-frame (during channel 1), then a full frame with the persisting kernels
    for (int ch = 0; ch < 2; ch++)
      for (int k = 0; k < 9; k++) kw[ch][k] = 16'($urandom);
    load_kernels(2);
    Image_size = 8'd3;
    for (int i = 0; i < 12; i++) send_beat(16'($urandom));
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    fill_img(2, 3, 16'd0, 1'b1);
    b = 48'({$urandom, $urandom});
    run_frame(3, 2, b);
    drain("drain_after_reset");

    // Randomized frames with random backpressure and input gaps
    rdy_mode = 2;
    gaps     = 1'b1;
    for (int it = 0; it < 6; it++) begin
      n = (it == 0) ? 1 : (it == 5) ? 8 : $urandom_range(2, 6);
      c = $urandom_range(1, 3);
      for (int ch = 0; ch < c; ch++)
        for (int k = 0; k < 9; k++) kw[ch][k] = 16'($urandom);
      load_kernels(c);
      fill_img(c, n, 16'd0, 1'b1);
      b = 48'({$urandom, $urandom});
      run_frame(n, c, b);
      drain("drain_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/convolution_top_alt.md
CONVOLUTION_TOP_ALT -- requirements
Module: convolution_top_alt

Interface
REQ-001 SHALL have ports: clk in 1, the single clock; aresetn in 1, reset, synchronous, active-low.
REQ-002 SHALL have ports: Load_kernel_BRAM in 1, kernel-load request; Image_size in 8, N (square N x N, 1..64); Channel_size in 9, C (1..256).
REQ-003 SHALL have ports: kernel_BRAM_doutb in 256, kernel word, bits [143:0] used; enb_kernel_BRAM out 1, kernel read enable; kernel_BRAM_counter_out out 8, kernel read address.
REQ-004 SHALL have port bias_BRAM_douta in 48, signed bias for the output map.
REQ-005 SHALL have ports: s_axis_tdata in 16, s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tlast in 1 (ignored; framing by counters).
REQ-006 SHALL have ports: m_axis_tdata out 64, m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tlast out 1.
REQ-007 SHALL use parameters: PIXEL_WIDTH 16, KERNEL_WIDTH 16, RESULT_WIDTH 48, MAX_IMG 64, MAX_CH 256.

Function
REQ-008 SHALL use FSM states IDLE, LOAD_K, RECV, COMP, OUT.
REQ-009 IDLE: Load_kernel_BRAM=1 -> LOAD_K (priority); else s_axis_tvalid=1 -> RECV, channel index 0.
REQ-010 LOAD_K: enb_kernel_BRAM=1; counter starts 0, +1 per cycle, holds at C-1; each cycle stores doutb[143:0] into kernel store [counter]; Load_kernel_BRAM=0 -> IDLE, counter cleared.
REQ-011 Kernel word: weight k = bits [16k+15:16k], k = 3*kr+kc, kr/kc 0..2, row-major from top-left.
REQ-012 RECV: s_axis_tready=1; each tvalid&tready beat writes the pixel to the frame buffer in raster order; after N*N beats -> COMP.
REQ-013 COMP: s_axis_tready=0; per output pixel (r,c) in raster order, 9 cycles, one tap per cycle: product = w[k] * pixel(r+kr-1, c+kc-1); out-of-range pixel = 0 (zero pad, stride 1, output N x N).
REQ-014 Arithmetic: signed 16x16 -> 32-bit product, sign-extended to 48; 48-bit wrap-around accumulation, no saturation.
REQ-015 Partial-sum buffer (MAX_IMG^2 x 48): channel 0 overwrites the entry with its 9-tap sum; later channels add to it.
REQ-016 Not last channel: after N*N pixels, channel+1 -> RECV. Last channel (C-1): each pixel goes to OUT after its 9 taps.
REQ-017 OUT: m_axis_tdata = sign-extend-64(psum + bias_BRAM_douta); m_axis_tvalid=1, held stable until m_axis_tready=1; m_axis_tlast=1 only on pixel N*N-1.
REQ-018 OUT handshake: next pixel -> COMP; after the last pixel -> IDLE.
REQ-019 Latency: first output valid 9 cycles after the last input beat of channel C-1.
REQ-020 enb_kernel_BRAM=0 outside LOAD_K; kernel store persists across frames until reloaded.

Reset
REQ-021 aresetn=0 at a clock edge SHALL force IDLE; all counters 0; enb_kernel_BRAM, s_axis_tready, m_axis_tvalid, m_axis_tlast 0; m_axis_tdata 0; kernel_BRAM_counter_out 0.
REQ-022 Kernel store, frame and psum buffers SHALL NOT be cleared by reset; reset mid-frame abandons the frame, and REQ-015 overwrite makes stale data harmless.

Structure
REQ-023 Shared package conv_pkg SHALL hold the width parameters, MAX_IMG, MAX_CH and the state enum.
REQ-024 Sub-module conv_mac_unit SHALL do the signed multiply, sign-extension and 48-bit accumulate/clear; FSM, counters and storage stay in the top.

Verification
REQ-025 Reset: hold aresetn=0 for 10 cycles -> all outputs 0, tready 0.
REQ-026 Load C=256 -> enb high; counter 0..255 then holds at 255; drop Load -> enb 0 next cycle.
REQ-027 N=4, C=1, all pixels 1, kernel w4=1 only, bias 0 -> 16 outputs all 1; tlast on the 16th only.
REQ-028 N=4, C=1, all pixels 1, all weights 1 -> corner outputs 4, edge outputs 6, interior outputs 9.
REQ-029 N=4, C=256, all pixels 1, w4=1 per channel, bias 5 -> 16 outputs of 261 (0x105).
REQ-030 N=4, C=1, pixel 0xFFFE, w4=3, m_axis_tready low 5 cycles -> output 0xFFFFFFFFFFFFFFFA held stable until accepted.
